clk_div_100ms: RTL and testbench

//  Clock-utility block for the game core. Provides a free-running 32-bit cycle

---
 rtl/clk_div_100ms.sv | 56 +++++
 tb/tb_clk_div_100ms.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/clk_div_100ms.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_100ms
// Brief    : Free-running 32-bit cycle counter plus a 50%-duty game-update
//            square wave with a one-cycle tick on each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module clk_div_100ms #(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int PERIOD_MS   = 100
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] clk_div,
    output logic        clk_100ms,
    output logic        tick_100ms
);

    localparam int HALF_CNT = CLK_FREQ_HZ / 1000 * PERIOD_MS / 2;
    // A one-cycle half period still needs a 1-bit counter to stay legal.
    localparam int HC_W = (HALF_CNT > 1) ? $clog2(HALF_CNT) : 1;
    localparam logic [HC_W-1:0] C_HC_MAX = HC_W'(HALF_CNT - 1);
    localparam logic [HC_W-1:0] C_HC_ONE = HC_W'(1);

    logic [31:0]     r_clk_div;
    logic [HC_W-1:0] r_hc;
    logic            r_clk_100ms;
    logic            r_tick;
    logic            w_half_done;

    assign w_half_done = (r_hc == C_HC_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_clk_div   <= 32'd0;
            r_hc        <= '0;
            r_clk_100ms <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_clk_div <= r_clk_div + 32'd1;
            if (w_half_done) begin
                r_hc        <= '0;
                r_clk_100ms <= ~r_clk_100ms;
            end else begin
                r_hc <= r_hc + C_HC_ONE;
            end
            r_tick <= w_half_done & ~r_clk_100ms;
        end
    end

    assign clk_div    = r_clk_div;
    assign clk_100ms  = r_clk_100ms;
    assign tick_100ms = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_100ms.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_100ms
// Brief    : Self-checking bench for clk_div_100ms (HALF_CNT=5 and HALF_CNT=1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_clk_div_100ms;

    localparam int H0 = 5;
    localparam int H1 = 1;

    logic        clk;
    logic        rst;
    logic [31:0] clk_div0, clk_div1;
    logic        clk_100ms0, clk_100ms1;
    logic        tick0, tick1;

    int tests = 0;
    int fails = 0;
    bit check_en = 0;

    // Cycles since reset release and expected counter value per instance
    int          m_n0 = 0, m_n1 = 0;
    logic [31:0] m_cnt0 = 0, m_cnt1 = 0;

    clk_div_100ms #(.CLK_FREQ_HZ(1000), .PERIOD_MS(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div0),
        .clk_100ms  (clk_100ms0),
        .tick_100ms (tick0)
    );

    clk_div_100ms #(.CLK_FREQ_HZ(2000), .PERIOD_MS(1)) dut1 (
        .clk        (clk),
        .rst        (rst),
        .clk_div    (clk_div1),
        .clk_100ms  (clk_100ms1),
        .tick_100ms (tick1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Square wave level after n cycles: which half-period we are in
    function automatic logic exp_clk(input int n, input int h);
        return ((n / h) % 2) == 1;
    endfunction

    function automatic logic exp_tick(input int n, input int h);
        return (n > 0) && ((n % (2 * h)) == h);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_n0 = 0; m_n1 = 0; m_cnt0 = 0; m_cnt1 = 0;
        end else begin
            m_n0++; m_n1++; m_cnt0 = m_cnt0 + 32'd1; m_cnt1 = m_cnt1 + 32'd1;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("clk_div0",   clk_div0,         m_cnt0);
            chk("clk_100ms0", {31'd0, clk_100ms0}, {31'd0, exp_clk(m_n0, H0)});
            chk("tick0",      {31'd0, tick0},      {31'd0, exp_tick(m_n0, H0)});
            chk("clk_div1",   clk_div1,         m_cnt1);
            chk("clk_100ms1", {31'd0, clk_100ms1}, {31'd0, exp_clk(m_n1, H1)});
            chk("tick1",      {31'd0, tick1},      {31'd0, exp_tick(m_n1, H1)});
        end
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_en = 1;
        chk("rst_div",  clk_div0, 32'd0);
        chk("rst_clk",  {31'd0, clk_100ms0}, 32'd0);
        chk("rst_tick", {31'd0, tick0}, 32'd0);

        rst = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            @(negedge clk);
            if (c == 4)  chk("lit_c4_clk",   {31'd0, clk_100ms0}, 32'd0);
            if (c == 5)  chk("lit_c5_clk",   {31'd0, clk_100ms0}, 32'd1);
            if (c == 5)  chk("lit_c5_tick",  {31'd0, tick0}, 32'd1);
            if (c == 10) chk("lit_c10_clk",  {31'd0, clk_100ms0}, 32'd0);
            if (c == 10) chk("lit_c10_tick", {31'd0, tick0}, 32'd0);
            if (c == 15) chk("lit_c15_clk",  {31'd0, clk_100ms0}, 32'd1);
            if (c == 15) chk("lit_c15_tick", {31'd0, tick0}, 32'd1);
            if (c == 20) chk("lit_c20_clk",  {31'd0, clk_100ms0}, 32'd0);
            if (c == 20) chk("lit_c20_tick", {31'd0, tick0}, 32'd0);
            if (c == 23) chk("lit_c23_div",  clk_div0, 32'd23);
        end

        // Mid-operation reset while the square wave is high
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (7) @(negedge clk);
        chk("lit_pre_rst_clk", {31'd0, clk_100ms0}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("lit_mid_rst_div", clk_div0, 32'd0);
        chk("lit_mid_rst_clk", {31'd0, clk_100ms0}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk("lit_rel4_clk", {31'd0, clk_100ms0}, 32'd0);
        @(negedge clk);
        chk("lit_rel5_clk",  {31'd0, clk_100ms0}, 32'd1);
        chk("lit_rel5_tick", {31'd0, tick0}, 32'd1);

        // Counter wrap via hierarchical force; square wave must keep its cadence
        #2;
        force dut.r_clk_div = 32'hFFFF_FFFE;
        m_cnt0 = 32'hFFFF_FFFE;
        #1;
        release dut.r_clk_div;
        @(negedge clk);
        chk("lit_wrap_ffff", clk_div0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("lit_wrap_zero", clk_div0, 32'h0000_0000);
        @(negedge clk);
        chk("lit_wrap_one",  clk_div0, 32'h0000_0001);

        // Randomized reset pulses and run lengths
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 24) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        repeat (30) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
